// File: rtl/vga_line_prefetch.sv
// rtl/vga_line_prefetch.sv - two-bank ping-pong line prefetcher feeding the VGA draw logic
// Serves 10-byte reads from cached framebuffer rows while fetching the next row over a 64-bit beat bus.
module vga_line_prefetch #(
  parameter int ROWS            = 240,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read_bytes,
  input  logic [39:0] vga_addr,
  output logic [79:0] rd_data,
  output logic        mem_req,
  output logic [39:0] mem_raddr,
  input  logic        mem_gnt,
  input  logic [63:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic        fill_busy,
  output logic        underrun
);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t state;

  logic [63:0] line_mem [2][32];
  logic [1:0]  tag_valid;
  logic [1:0]  tag_fb;
  logic [7:0]  tag_row [2];
  logic        cur_valid, cur_bank;
  logic        fill_bank, fill_fb;
  logic [7:0]  fill_row;
  logic [5:0]  issue_cnt, ret_cnt;
  logic [OW-1:0] outstanding;
  logic        pend_valid, pend_bank, pend_fb;
  logic [7:0]  pend_row;

  logic        rd_fb;
  logic [7:0]  rd_row, rd_col, succ_row;
  logic [1:0]  bank_match;
  logic        hit, miss, hit_bank, other_bank, other_has_succ, miss_bank;
  logic [79:0] hit_bytes;
  logic [8:0]  byte_addr;
  logic        gnt_fire, ret_fire;
  logic [OW-1:0] out_nxt;
  logic [5:0]  issue_nxt, ret_nxt;
  logic        start_fill, start_bank, start_fb;
  logic [7:0]  start_row;
  logic        unused_ok;

  assign unused_ok = ^vga_addr[39:17];
  assign rd_fb     = vga_addr[16];
  assign rd_row    = vga_addr[15:8];
  assign rd_col    = vga_addr[7:0];
  assign mem_raddr = {23'd0, fill_fb, fill_row, issue_cnt[4:0], 3'b000};

  // A bank being refilled has its valid bit cleared, so it can never match here.
  assign bank_match[0] = tag_valid[0] && tag_fb[0] == rd_fb && tag_row[0] == rd_row;
  assign bank_match[1] = tag_valid[1] && tag_fb[1] == rd_fb && tag_row[1] == rd_row;
  assign hit        = read_bytes && (|bank_match);
  assign miss       = read_bytes && !(|bank_match);
  assign hit_bank   = !bank_match[0];
  assign other_bank = !hit_bank;
  assign miss_bank  = cur_valid ? !cur_bank : 1'b0;
  assign succ_row   = (rd_row == 8'(ROWS - 1)) ? 8'd0 : rd_row + 8'd1;

  assign other_has_succ =
      (tag_valid[other_bank] && tag_fb[other_bank] == rd_fb && tag_row[other_bank] == succ_row) ||
      (state != IDLE && fill_bank == other_bank && fill_fb == rd_fb && fill_row == succ_row);

  assign gnt_fire  = mem_req && mem_gnt;
  assign ret_fire  = mem_rvalid && (outstanding != '0);
  assign out_nxt   = outstanding + OW'(gnt_fire) - OW'(ret_fire);
  assign issue_nxt = issue_cnt + 6'(gnt_fire);
  assign ret_nxt   = ret_cnt + 6'(ret_fire);

  always_comb begin
    hit_bytes = '0;
    byte_addr = '0;
    for (int i = 0; i < 10; i++) begin
      byte_addr = {1'b0, rd_col} + 9'(i);
      if (!byte_addr[8])
        hit_bytes[i*8 +: 8] = line_mem[hit_bank][byte_addr[7:3]][{byte_addr[2:0], 3'b000} +: 8];
    end
  end

  // A live miss beats a stored one, which in turn beats a hit-triggered prefetch.
  always_comb begin
    start_fill = 1'b0;
    start_bank = 1'b0;
    start_fb   = 1'b0;
    start_row  = '0;
    if (state == IDLE) begin
      if (miss) begin
        start_fill = 1'b1; start_bank = miss_bank; start_fb = rd_fb; start_row = rd_row;
      end else if (pend_valid) begin
        start_fill = 1'b1; start_bank = pend_bank; start_fb = pend_fb; start_row = pend_row;
      end else if (hit && !other_has_succ) begin
        start_fill = 1'b1; start_bank = other_bank; start_fb = rd_fb; start_row = succ_row;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && ret_fire)
      line_mem[fill_bank][ret_cnt[4:0]] <= mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rd_data     <= '0;
      mem_req     <= 1'b0;
      fill_busy   <= 1'b0;
      underrun    <= 1'b0;
      tag_valid   <= '0;
      tag_fb      <= '0;
      tag_row[0]  <= '0;
      tag_row[1]  <= '0;
      cur_valid   <= 1'b0;
      cur_bank    <= 1'b0;
      fill_bank   <= 1'b0;
      fill_fb     <= 1'b0;
      fill_row    <= '0;
      issue_cnt   <= '0;
      ret_cnt     <= '0;
      outstanding <= '0;
      pend_valid  <= 1'b0;
      pend_bank   <= 1'b0;
      pend_fb     <= 1'b0;
      pend_row    <= '0;
    end else begin
      underrun    <= miss;
      outstanding <= out_nxt;
      ret_cnt     <= ret_nxt;
      if (read_bytes)
        rd_data <= hit ? hit_bytes : '0;
      if (hit) begin
        cur_valid <= 1'b1;
        cur_bank  <= hit_bank;
      end
      if (miss && state != IDLE) begin
        pend_valid <= 1'b1;
        pend_bank  <= miss_bank;
        pend_fb    <= rd_fb;
        pend_row   <= rd_row;
      end
      case (state)
        IDLE: if (start_fill) begin
          state                 <= ISSUE;
          fill_busy             <= 1'b1;
          mem_req               <= 1'b1;
          fill_bank             <= start_bank;
          fill_fb               <= start_fb;
          fill_row              <= start_row;
          tag_valid[start_bank] <= 1'b0;
          issue_cnt             <= '0;
          ret_cnt               <= '0;
          pend_valid            <= 1'b0;
        end
        ISSUE: begin
          issue_cnt <= issue_nxt;
          if (issue_nxt == 6'd32) begin
            state   <= DRAIN;
            mem_req <= 1'b0;
          end else begin
            mem_req <= (out_nxt < OW'(MAX_OUTSTANDING));
          end
        end
        DRAIN: if (ret_nxt == 6'd32) state <= DONE;
        DONE: begin
          tag_valid[fill_bank] <= 1'b1;
          tag_fb[fill_bank]    <= fill_fb;
          tag_row[fill_bank]   <= fill_row;
          fill_busy            <= 1'b0;
          state                <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vga_line_prefetch.sv
// tb/tb_vga_line_prefetch.sv - scoreboard bench for vga_line_prefetch with a tag-level reference model
// Memory responder, read scoreboard and fill-address expectations are all generated bench-side.
module tb_vga_line_prefetch;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        read_bytes = 1'b0;
  logic [39:0] vga_addr = '0;
  logic [79:0] rd_data;
  logic        mem_req;
  logic [39:0] mem_raddr;
  logic        mem_gnt = 1'b0;
  logic [63:0] mem_rdata = '0;
  logic        mem_rvalid = 1'b0;
  logic        fill_busy;
  logic        underrun;

  always #20 clk = ~clk;

  vga_line_prefetch #(.ROWS(240), .MAX_OUTSTANDING(4)) dut (
    .clk(clk), .rst(rst), .read_bytes(read_bytes), .vga_addr(vga_addr), .rd_data(rd_data),
    .mem_req(mem_req), .mem_raddr(mem_raddr), .mem_gnt(mem_gnt), .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid), .fill_busy(fill_busy), .underrun(underrun)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Framebuffer contents: byte value as a function of {fb,row,col}; row 0 of fb 0 reads back its column.
  function automatic logic [7:0] pat(logic fb, int row, int col);
    return 8'((col + 37 * row + (fb ? 128 : 0)) % 256);
  endfunction

  function automatic logic [63:0] word_of(logic [39:0] a);
    logic [63:0] w;
    for (int k = 0; k < 8; k++) w[k*8 +: 8] = pat(a[16], int'(a[15:8]), int'(a[7:0]) + k);
    return w;
  endfunction

  typedef struct { logic fb; int row; } line_t;
  typedef struct { logic [79:0] data; logic und; } rd_exp_t;
  typedef struct { logic [39:0] addr; int t; } ret_t;

  logic m_valid [2];
  logic m_fb [2];
  int   m_row [2];
  logic m_cur_valid, m_fill_active, m_fill_fb, m_pend_valid, m_pend_fb;
  int   m_cur, m_fill_bank, m_fill_row, m_pend_bank, m_pend_row;
  int   quiet = 0;
  line_t   exp_fill [$];
  rd_exp_t sb [$];

  function automatic void model_reset();
    for (int b = 0; b < 2; b++) begin m_valid[b] = 1'b0; m_fb[b] = 1'b0; m_row[b] = -1; end
    m_cur_valid = 1'b0; m_cur = 0;
    m_fill_active = 1'b0; m_pend_valid = 1'b0;
    exp_fill.delete();
  endfunction

  function automatic void model_start(int bank, logic fb, int row);
    m_valid[bank] = 1'b0;
    m_fill_active = 1'b1; m_fill_bank = bank; m_fill_fb = fb; m_fill_row = row;
    exp_fill.push_back('{fb: fb, row: row});
  endfunction

  function automatic void model_complete();
    m_valid[m_fill_bank] = 1'b1; m_fb[m_fill_bank] = m_fill_fb; m_row[m_fill_bank] = m_fill_row;
    m_fill_active = 1'b0;
    quiet = 0;
    if (m_pend_valid) begin
      m_pend_valid = 1'b0;
      model_start(m_pend_bank, m_pend_fb, m_pend_row);
    end
  endfunction

  function automatic void model_read(logic fb, int row, int col);
    int h = -1;
    int succ, oth, tgt;
    logic have;
    logic [79:0] d = '0;
    for (int b = 0; b < 2; b++)
      if (h < 0 && m_valid[b] && m_fb[b] == fb && m_row[b] == row && !(m_fill_active && m_fill_bank == b)) h = b;
    if (h >= 0) begin
      for (int i = 0; i < 10; i++) if (col + i <= 255) d[i*8 +: 8] = pat(fb, row, col + i);
      sb.push_back('{data: d, und: 1'b0});
      m_cur_valid = 1'b1; m_cur = h;
      succ = (row == 239) ? 0 : row + 1;
      oth  = 1 - h;
      have = (m_valid[oth] && m_fb[oth] == fb && m_row[oth] == succ) ||
             (m_fill_active && m_fill_bank == oth && m_fill_fb == fb && m_fill_row == succ);
      if (!m_fill_active && !have) model_start(oth, fb, succ);
    end else begin
      sb.push_back('{data: '0, und: 1'b1});
      tgt = m_cur_valid ? 1 - m_cur : 0;
      if (m_fill_active) begin
        m_pend_valid = 1'b1; m_pend_bank = tgt; m_pend_fb = fb; m_pend_row = row;
      end else begin
        model_start(tgt, fb, row);
      end
    end
  endfunction

  // Memory responder: in-order returns with a per-beat latency, optional forced stall, stray returns when idle.
  ret_t  rq [$];
  ret_t  rr;
  line_t cl;
  int    cyc = 0, out_b = 0, beat_idx = 0, ret_idx = 0, stall_left = 0;
  int    gnt_pct = 100, lat_min = 1, lat_max = 1;
  logic  rsp_g, prev_stall = 1'b0;
  logic [39:0] prev_addr = '0;

  always @(negedge clk) begin
    cyc++;
    if (m_fill_active) quiet = 0; else quiet++;
    if (rst) begin
      rq.delete(); exp_fill.delete();
      out_b = 0; beat_idx = 0; ret_idx = 0; prev_stall = 1'b0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
    end else begin
      if (prev_stall && mem_req) check("raddr_stable", mem_raddr, prev_addr);
      rsp_g = 1'b0;
      if (mem_req) begin
        if (stall_left > 0) stall_left--;
        else rsp_g = ($urandom_range(99) < gnt_pct);
      end
      if (rsp_g) begin
        check("outstanding_limit", out_b < 4, 1);
        if (beat_idx == 0) begin
          if (exp_fill.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_fill: got addr 0x%0h, want no fill", mem_raddr);
            cl = '{fb: 1'b0, row: 0};
          end else cl = exp_fill.pop_front();
        end
        check("fill_addr", mem_raddr, {23'd0, cl.fb, 8'(cl.row), 5'(beat_idx), 3'b000});
        rq.push_back('{addr: mem_raddr, t: cyc + $urandom_range(lat_max, lat_min)});
        beat_idx = (beat_idx + 1) % 32;
        out_b++;
      end
      mem_gnt    = rsp_g;
      prev_stall = mem_req && !rsp_g;
      prev_addr  = mem_raddr;
      mem_rvalid = 1'b0;
      mem_rdata  = {$urandom, $urandom};
      if (rq.size() > 0 && rq[0].t <= cyc) begin
        rr = rq.pop_front();
        mem_rvalid = 1'b1;
        mem_rdata  = word_of(rr.addr);
        out_b--;
        ret_idx++;
        if (ret_idx == 32) begin ret_idx = 0; model_complete(); end
      end else if (out_b == 0 && $urandom_range(9) == 0) begin
        mem_rvalid = 1'b1;
      end
    end
  end

  // Read monitor: pops the scoreboard for every read, otherwise rd_data must hold and underrun stay low.
  logic rst_q = 1'b1, rd_q = 1'b0;
  logic [79:0] last_exp = '0;
  rd_exp_t e;
  always @(posedge clk) begin rst_q <= rst; rd_q <= read_bytes; end
  always @(negedge clk) begin
    if (rst_q) begin
      sb.delete(); last_exp = '0;
    end else if (rd_q) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL sb_empty: got a read response, want none pending");
      end else begin
        e = sb.pop_front();
        check("rd_data", rd_data, e.data);
        check("underrun", underrun, e.und);
        last_exp = e.data;
      end
    end else begin
      check("hold_no_underrun", {underrun, rd_data}, {1'b0, last_exp});
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((m_fill_active || quiet < 5) && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) begin
      n_checks++;
      $display("FAIL idle_timeout: got fill still active after %0d cycles, want completion", n);
      m_fill_active = 1'b0;
    end
  endtask

  task automatic issue_read(logic fb, int row, int col);
    logic [39:0] a;
    a = {$urandom, $urandom};
    a[16] = fb; a[15:8] = 8'(row); a[7:0] = 8'(col);
    vga_addr = a;
    read_bytes = 1'b1;
    model_read(fb, row, col);
    @(negedge clk);
    read_bytes = 1'b0;
  endtask

  task automatic do_read(logic fb, int row, int col);
    wait_idle();
    issue_read(fb, row, col);
  endtask

  task automatic wait_beats(int k);
    int n = 0;
    while (beat_idx < k && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) begin n_checks++; $display("FAIL beat_timeout: got %0d beats, want %0d", beat_idx, k); end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; read_bytes = 1'b0;
    model_reset();
    @(negedge clk);
    check("rst_mem_req", mem_req, 0);
    check("rst_fill_busy", fill_busy, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  int rows_pick [6] = '{0, 1, 2, 238, 239, 100};

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check("init_mem_req", mem_req, 0);
    check("init_fill_busy", fill_busy, 0);
    check("init_rd_data", rd_data, 0);
    check("init_underrun", underrun, 0);
    rst = 1'b0;
    @(negedge clk);

    do_read(1'b0, 0, 0);
    do_read(1'b0, 0, 0);
    do_read(1'b0, 0, 250);
    do_read(1'b1, 239, 5);
    do_read(1'b1, 239, 5);

    wait_idle();
    stall_left = 5; gnt_pct = 100; lat_min = 10; lat_max = 10;
    do_read(1'b0, 50, 0);
    wait_idle();
    do_read(1'b0, 50, 17);
    lat_min = 1; lat_max = 3;

    do_read(1'b0, 100, 3);
    wait_beats(3);
    issue_read(1'b0, 7, 0);
    issue_read(1'b0, 9, 0);
    do_read(1'b0, 9, 0);
    do_read(1'b0, 100, 200);

    for (int i = 0; i < 100; i++) begin
      gnt_pct = $urandom_range(100, 40);
      lat_min = 1;
      lat_max = $urandom_range(6, 1);
      do_read(1'($urandom_range(1)), rows_pick[$urandom_range(5)],
              ($urandom_range(3) == 0) ? $urandom_range(255, 246) : $urandom_range(255));
      repeat ($urandom_range(2)) @(negedge clk);
    end

    wait_idle();
    gnt_pct = 100; lat_max = 2;
    do_read(1'b0, 120, 0);
    wait_beats(5);
    do_reset();
    do_read(1'b0, 0, 0);
    wait_idle();
    repeat (3) @(negedge clk);
    check("all_fills_seen", exp_fill.size(), 0);
    check("beats_aligned", beat_idx, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    repeat (60000) @(posedge clk);
    n_checks++;
    $display("FAIL watchdog: got no completion after 60000 cycles, want finish");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
